// File: rtl/rega_multizona_ctrl.sv
// Multi-zone irrigation controller: tank level decode, inlet valve hysteresis,
// and round-robin timed watering (sprinkler or drip) across NZONES beds.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | scanning zones one per cycle, waiting for a dry zone
// S_WATER | one zone's valve is open, countdown running on tick
// S_DONE  | one-cycle close-out: valves shut, timer cleared, ptr advanced
module rega_multizona_ctrl #(
  parameter int NZONES        = 4,
  parameter int TIME_W        = 8,
  parameter int SPRINKLE_TIME = 30,
  parameter int DRIP_TIME     = 90,
  parameter int ZW            = $clog2(NZONES)
) (
  input  logic              clock,
  input  logic              Rst,
  input  logic              tick,
  input  logic              H,
  input  logic              M,
  input  logic              L,
  input  logic              Ua,
  input  logic              T,
  input  logic [NZONES-1:0] Us,
  output logic [NZONES-1:0] Bs,
  output logic [NZONES-1:0] Vs,
  output logic              Ve,
  output logic              Al,
  output logic              ERRO,
  output logic [ZW-1:0]     zone,
  output logic [TIME_W-1:0] time_left,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WATER = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t              state, state_nx;
  logic [ZW-1:0]       ptr, ptr_nx, ptr_inc;
  logic [TIME_W-1:0]   timer, timer_nx;
  logic                mode_spr, mode_spr_nx;

  logic                crit, err, ok_drip, ok_spr, want_spr;
  logic                us_sel, abort, early;

  logic [NZONES-1:0]   bs_nx, vs_nx, sel_oh;
  logic                ve_nx, busy_nx;

  assign crit     = ~L;
  assign err      = (H & ~M) | (M & ~L);
  assign ok_drip  = L & ~err;
  assign ok_spr   = M & ~err;
  assign want_spr = ~T & ~Ua & ok_spr;

  assign us_sel  = Us[ptr];
  assign ptr_inc = (ptr == ZW'(NZONES - 1)) ? '0 : ptr + 1'b1;

  // A sprinkler needs the mid level; losing it ends the turn rather than
  // falling back to drip, so the mode never changes mid-watering.
  assign abort = err | crit | (mode_spr & ~M);
  assign early = ~us_sel;

  always_ff @(posedge clock) begin
    if (Rst) begin
      state     <= S_IDLE;
      ptr       <= '0;
      timer     <= '0;
      mode_spr  <= 1'b0;
      Bs        <= '0;
      Vs        <= '0;
      Ve        <= 1'b0;
      Al        <= 1'b0;
      ERRO      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      ptr       <= ptr_nx;
      timer     <= timer_nx;
      mode_spr  <= mode_spr_nx;
      Bs        <= bs_nx;
      Vs        <= vs_nx;
      Ve        <= ve_nx;
      Al        <= err | crit;
      ERRO      <= err;
      busy      <= busy_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    timer_nx    = timer;
    mode_spr_nx = mode_spr;
    case (state)
      S_IDLE: begin
        if (us_sel && ok_drip) begin
          state_nx    = S_WATER;
          mode_spr_nx = want_spr;
          timer_nx    = want_spr ? TIME_W'(SPRINKLE_TIME) : TIME_W'(DRIP_TIME);
        end else begin
          ptr_nx = ptr_inc;
        end
      end
      S_WATER: begin
        // Abort and early end win over a coincident tick: timer is left as is.
        if (abort || early) begin
          state_nx = S_DONE;
        end else if (tick) begin
          timer_nx = timer - 1'b1;
          if (timer == TIME_W'(1)) begin
            state_nx = S_DONE;
          end
        end
      end
      S_DONE: begin
        state_nx = S_IDLE;
        timer_nx = '0;
        ptr_nx   = ptr_inc;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

  // Output values are computed from the next state so the registered valves
  // open and close on the same edge as the state change.
  always_comb begin
    sel_oh  = NZONES'(1) << ptr_nx;
    bs_nx   = '0;
    vs_nx   = '0;
    busy_nx = (state_nx == S_WATER);
    if (state_nx == S_WATER) begin
      if (mode_spr_nx) begin
        bs_nx = sel_oh;
      end else begin
        vs_nx = sel_oh;
      end
    end
    ve_nx = Ve;
    if (~M & ~err) begin
      ve_nx = 1'b1;
    end else if (H | err) begin
      ve_nx = 1'b0;
    end
  end

  assign zone      = ptr;
  assign time_left = timer;

endmodule

// File: tb/tb_rega_multizona_ctrl.sv
// Bench for rega_multizona_ctrl: directed stimulus feeds a scoreboard of
// cycle-stamped output checks plus a queue of expected watering starts.
module tb_rega_multizona_ctrl;

  logic       clock = 1'b0;
  logic       Rst, tick, H, M, L, Ua, T;
  logic [3:0] Us;
  logic [3:0] Bs, Vs;
  logic       Ve, Al, ERRO, busy;
  logic [1:0] zone;
  logic [7:0] time_left;

  rega_multizona_ctrl dut (
    .clock(clock), .Rst(Rst), .tick(tick), .H(H), .M(M), .L(L), .Ua(Ua), .T(T),
    .Us(Us), .Bs(Bs), .Vs(Vs), .Ve(Ve), .Al(Al), .ERRO(ERRO), .zone(zone),
    .time_left(time_left), .busy(busy)
  );

  always #5 clock = ~clock;

  // obs layout: {Bs[21:18], Vs[17:14], Ve[13], Al[12], ERRO[11], zone[10:9], time_left[8:1], busy[0]}
  localparam logic [21:0] M_BS   = 22'h3C0000;
  localparam logic [21:0] M_VS   = 22'h03C000;
  localparam logic [21:0] M_VE   = 22'h002000;
  localparam logic [21:0] M_AL   = 22'h001000;
  localparam logic [21:0] M_ERRO = 22'h000800;
  localparam logic [21:0] M_ZONE = 22'h000600;
  localparam logic [21:0] M_TL   = 22'h0001FE;
  localparam logic [21:0] M_BUSY = 22'h000001;
  localparam logic [21:0] M_ALL  = 22'h3FFFFF;
  localparam logic [21:0] M_WAT  = M_BS | M_VS | M_ZONE | M_TL | M_BUSY;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  logic finish_req = 1'b0;

  string       q_name[$];
  int          q_cyc[$];
  logic [21:0] q_exp[$];
  logic [21:0] q_mask[$];

  string       s_name[$];
  logic [17:0] s_exp[$];

  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [21:0] pk(input logic [3:0] bs, input logic [3:0] vs,
                                     input logic ve, input logic al, input logic er,
                                     input logic [1:0] z, input logic [7:0] tl,
                                     input logic b);
    return {bs, vs, ve, al, er, z, tl, b};
  endfunction

  task automatic expect_at(input string nm, input int d, input logic [21:0] e,
                           input logic [21:0] m);
    q_name.push_back(nm);
    q_cyc.push_back(cyc + d);
    q_exp.push_back(e);
    q_mask.push_back(m);
  endtask

  task automatic start_exp(input string nm, input logic [1:0] z, input logic [3:0] bs,
                           input logic [3:0] vs, input logic [7:0] tl);
    s_name.push_back(nm);
    s_exp.push_back({z, bs, vs, tl});
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic level(input logic [2:0] hml);
    {H, M, L} = hml;
  endtask

  task automatic pulse(input int n);
    repeat (n) begin
      tick = 1'b1;
      cycles(1);
      tick = 1'b0;
      cycles(1);
    end
  endtask

  task automatic wait_busy(input string nm);
    int n;
    n = 0;
    while (busy !== 1'b1 && n < 40) begin
      cycles(1);
      n++;
    end
    expect_at(nm, 0, 22'h000001, M_BUSY);
  endtask

  // Monitor: checks stamped expectations and every rising edge of busy.
  initial begin
    logic [21:0] obs;
    logic [17:0] act;
    logic        busy_q;
    busy_q = 1'b0;
    forever begin
      @(negedge clock);
      obs = {Bs, Vs, Ve, Al, ERRO, zone, time_left, busy};
      for (int i = q_cyc.size() - 1; i >= 0; i--) begin
        if (q_cyc[i] <= cyc) begin
          total++;
          if (q_cyc[i] < cyc) begin
            bad++;
            $display("FAIL %s: check slot %0d missed at cycle %0d", q_name[i], q_cyc[i], cyc);
          end else if (((obs ^ q_exp[i]) & q_mask[i]) !== 22'h0) begin
            bad++;
            $display("FAIL %s: got %h want %h (mask %h) cycle %0d",
                     q_name[i], obs & q_mask[i], q_exp[i] & q_mask[i], q_mask[i], cyc);
          end
          q_name.delete(i);
          q_cyc.delete(i);
          q_exp.delete(i);
          q_mask.delete(i);
        end
      end
      if (busy === 1'b1 && busy_q !== 1'b1) begin
        act = {zone, Bs, Vs, time_left};
        total++;
        if (s_exp.size() == 0) begin
          bad++;
          $display("FAIL unexpected_start: got zone/Bs/Vs/tl %h want none", act);
        end else begin
          if (act !== s_exp[0]) begin
            bad++;
            $display("FAIL %s: got zone/Bs/Vs/tl %h want %h", s_name[0], act, s_exp[0]);
          end
          void'(s_name.pop_front());
          void'(s_exp.pop_front());
        end
      end
      busy_q = busy;
      if (finish_req) begin
        for (int i = 0; i < q_name.size(); i++) begin
          total++;
          bad++;
          $display("FAIL %s: never checked, got none want slot %0d", q_name[i], q_cyc[i]);
        end
        for (int i = 0; i < s_name.size(); i++) begin
          total++;
          bad++;
          $display("FAIL %s: start never seen, got none want %h", s_name[i], s_exp[i]);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish by 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    Rst = 1'b1; tick = 1'b0; Ua = 1'b0; T = 1'b0; Us = 4'b0000;
    level(3'b000);
    cycles(2);
    expect_at("reset_all", 0, 22'h0, M_ALL);
    cycles(1);
    Rst = 1'b0;

    // level decode and alarms
    level(3'b011);
    expect_at("lvl_011", 1, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0),
              M_ERRO | M_AL | M_VE | M_BS | M_VS | M_BUSY);
    cycles(2);
    level(3'b101);
    expect_at("lvl_101", 1, pk(4'h0, 4'h0, 1'b0, 1'b1, 1'b1, 2'd0, 8'd0, 1'b0),
              M_ERRO | M_AL | M_VE | M_BS | M_VS | M_BUSY);
    cycles(2);
    level(3'b000);
    expect_at("lvl_000", 1, pk(4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0, 8'd0, 1'b0),
              M_ERRO | M_AL | M_VE);
    cycles(2);

    // inlet valve hysteresis
    level(3'b001);
    expect_at("ve_001_set", 1, pk(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0),
              M_VE | M_AL | M_ERRO);
    cycles(2);
    level(3'b011);
    expect_at("ve_011_hold1", 1, pk(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0), M_VE);
    cycles(2);
    level(3'b111);
    expect_at("ve_111_clr", 1, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0), M_VE);
    cycles(2);
    level(3'b011);
    expect_at("ve_011_hold0", 1, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0), M_VE);
    cycles(2);

    // sprinkler run to normal end on zone 2
    level(3'b111);
    start_exp("spr_start_z2", 2'd2, 4'b0100, 4'b0000, 8'd30);
    Us = 4'b0100;
    wait_busy("spr_busy");
    pulse(29);
    expect_at("spr_tl1", 0, pk(4'b0100, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd1, 1'b1), M_WAT);
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    expect_at("spr_end", 0, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0), M_WAT);
    Us = 4'b0000;
    expect_at("spr_next_zone", 1, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0), M_WAT);
    cycles(2);

    // drip with early stop; the coincident tick must not decrement
    T = 1'b1;
    start_exp("drip_start_z0", 2'd0, 4'b0000, 4'b0001, 8'd90);
    Us = 4'b0001;
    wait_busy("drip_busy");
    pulse(5);
    expect_at("drip_tl85", 0, pk(4'h0, 4'b0001, 1'b0, 1'b0, 1'b0, 2'd0, 8'd85, 1'b1), M_WAT);
    Us = 4'b0000;
    tick = 1'b1;
    cycles(1);
    tick = 1'b0;
    expect_at("drip_early", 0, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd85, 1'b0), M_WAT);
    expect_at("drip_next", 1, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0), M_WAT);
    cycles(2);

    // sprinkler abort on zone 1, then fair rescan before restarting as drip
    T = 1'b0;
    start_exp("abort_start_z1", 2'd1, 4'b0010, 4'b0000, 8'd30);
    Us = 4'b0010;
    wait_busy("abort_busy");
    pulse(2);
    level(3'b001);
    cycles(1);
    expect_at("abort_valves", 0, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd28, 1'b0),
              M_WAT | M_AL);
    start_exp("refill_z1_drip", 2'd1, 4'b0000, 4'b0010, 8'd90);
    expect_at("fair_z2", 1, pk(4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 2'd2, 8'd0, 1'b0),
              M_ZONE | M_BUSY | M_BS | M_VS | M_VE);
    expect_at("fair_z3", 2, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd3, 8'd0, 1'b0),
              M_ZONE | M_BUSY | M_BS | M_VS);
    expect_at("fair_z0", 3, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd0, 8'd0, 1'b0),
              M_ZONE | M_BUSY | M_BS | M_VS);
    expect_at("fair_z1", 4, pk(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 1'b0),
              M_ZONE | M_BUSY | M_BS | M_VS);
    expect_at("fair_restart", 5, pk(4'h0, 4'b0010, 1'b0, 1'b0, 1'b0, 2'd1, 8'd0, 1'b1),
              M_ZONE | M_BUSY | M_BS | M_VS);
    cycles(5);
    Us = 4'b0000;
    cycles(3);

    // round robin from a fresh reset, then reset mid-watering
    level(3'b111);
    Rst = 1'b1;
    cycles(1);
    Rst = 1'b0;
    Us = 4'b1111;
    start_exp("rr_z0", 2'd0, 4'b0001, 4'b0000, 8'd30);
    start_exp("rr_z1", 2'd1, 4'b0010, 4'b0000, 8'd30);
    start_exp("rr_z2", 2'd2, 4'b0100, 4'b0000, 8'd30);
    start_exp("rr_z3", 2'd3, 4'b1000, 4'b0000, 8'd30);
    start_exp("rr_z0_again", 2'd0, 4'b0001, 4'b0000, 8'd30);
    for (int k = 0; k < 4; k++) begin
      wait_busy("rr_busy");
      pulse(30);
    end
    wait_busy("rr_busy_last");
    pulse(3);
    Rst = 1'b1;
    Us = 4'b0000;
    cycles(1);
    expect_at("rst_mid_water", 0, 22'h0, M_ALL);
    cycles(1);
    Rst = 1'b0;
    cycles(2);
    finish_req = 1'b1;
  end

endmodule
